// File: rtl/sha3_mem_pkg.sv
// rtl/sha3_mem_pkg.sv - shared constants and types for the SHA3 memory responder
// Purpose: command encodings, request/response field widths and the response
//          record carried through the delay pipeline.
// Ports:   none (package).
package sha3_mem_pkg;

  localparam int ADDR_W = 40;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 64;
  localparam int CMD_W  = 5;

  localparam logic [CMD_W-1:0] M_XRD = 5'd0;
  localparam logic [CMD_W-1:0] M_XWR = 5'd1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } mem_resp_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
    return (cmd == M_XRD) || (cmd == M_XWR);
  endfunction

endpackage

// File: rtl/sha3_mem_responder_delay_pipe.sv
// rtl/sha3_mem_responder_delay_pipe.sv - fixed-latency response shift pipeline
// Purpose: delays a response record by exactly LATENCY clock edges.
// Ports:   clock, reset (async active-low clear of every stage),
//          in_valid/in_tag/in_data (entry captured every edge),
//          out_valid/out_tag/out_data (last stage), any_valid (some stage valid).
module resp_delay_pipe
  import sha3_mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic              any_valid
);

  mem_resp_t [LATENCY-1:0] stage_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{valid: in_valid, tag: in_tag, data: in_data};
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_tag   = stage_q[LATENCY-1].tag;
  assign out_data  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/sha3_mem_responder.sv
// rtl/sha3_mem_responder.sv - fixed-latency 64-bit word memory responder
// Purpose: accepts read/write requests into a word-addressed backing store and
//          returns one response per legal request exactly LATENCY cycles later.
// Ports:   clock, reset (async active-low);
//          io_mem_req_* request handshake (ready/valid, addr, tag, cmd, data);
//          io_mem_resp_* response strobe with tag and read data;
//          err_bad_cmd, err_misaligned sticky error flags; busy (responses in flight).
module sha3_mem_responder
  import sha3_mem_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 8,
  parameter int LATENCY        = 2,
  parameter int STALL_PERIOD   = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_mem_req_ready,
  input  logic              io_mem_req_valid,
  input  logic [ADDR_W-1:0] io_mem_req_bits_addr,
  input  logic [TAG_W-1:0]  io_mem_req_bits_tag,
  input  logic [CMD_W-1:0]  io_mem_req_bits_cmd,
  input  logic [DATA_W-1:0] io_mem_req_bits_data,
  output logic              io_mem_resp_valid,
  output logic [TAG_W-1:0]  io_mem_resp_bits_tag,
  output logic [DATA_W-1:0] io_mem_resp_bits_data,
  output logic              err_bad_cmd,
  output logic              err_misaligned,
  output logic              busy
);

  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam int CNT_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  logic [DATA_W-1:0]         mem_q [MEM_WORDS];
  logic [CNT_W-1:0]          stall_cnt_q;
  logic                      stall_q;
  logic                      accept;
  logic                      cmd_legal;
  logic                      is_read;
  logic                      is_write;
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic                      new_valid;
  logic [TAG_W-1:0]          new_tag;
  logic [DATA_W-1:0]         new_data;
  logic                      unused_addr_bits;

  assign io_mem_req_ready = !stall_q;
  assign accept           = io_mem_req_valid && io_mem_req_ready;
  assign cmd_legal        = cmd_is_legal(io_mem_req_bits_cmd);
  assign is_read          = io_mem_req_bits_cmd == M_XRD;
  assign is_write         = io_mem_req_bits_cmd == M_XWR;

  // Upper address bits alias onto the store; byte offset never selects data.
  assign word_idx         = io_mem_req_bits_addr[MEM_WORDS_LOG2+2:3];
  assign unused_addr_bits = ^io_mem_req_bits_addr[ADDR_W-1:MEM_WORDS_LOG2+3];

  // Store holds no reset so contents survive a responder reset.
  always_ff @(posedge clock) begin
    if (accept && is_write) begin
      mem_q[word_idx] <= io_mem_req_bits_data;
    end
  end

  // Read data is taken from the store before this edge's write would land,
  // which is harmless since only one request is accepted per cycle.
  // Invalid entries carry zero tag/data so the outputs idle at zero.
  always_comb begin
    new_valid = 1'b0;
    new_tag   = '0;
    new_data  = '0;
    if (accept && cmd_legal) begin
      new_valid = 1'b1;
      new_tag   = io_mem_req_bits_tag;
      if (is_read) begin
        new_data = mem_q[word_idx];
      end
    end
  end

  // Every STALL_PERIOD-th accept drops ready for exactly the next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if ((STALL_PERIOD > 0) && accept) begin
        if (stall_cnt_q == CNT_W'(STALL_PERIOD - 1)) begin
          stall_cnt_q <= '0;
          stall_q     <= 1'b1;
        end else begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_bad_cmd    <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      if (accept && !cmd_legal) begin
        err_bad_cmd <= 1'b1;
      end
      if (accept && (io_mem_req_bits_addr[2:0] != 3'b000)) begin
        err_misaligned <= 1'b1;
      end
    end
  end

  resp_delay_pipe #(
    .LATENCY (LATENCY)
  ) u_delay_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (new_valid),
    .in_tag    (new_tag),
    .in_data   (new_data),
    .out_valid (io_mem_resp_valid),
    .out_tag   (io_mem_resp_bits_tag),
    .out_data  (io_mem_resp_bits_data),
    .any_valid (busy)
  );

endmodule
